// File: rtl/sdram_responder.sv
// sdram_responder: memory-side SDRAM command decoder with bank/timing tracking.
// Serves sequential-wrap bursts from a small backing store; flags protocol errors.
module sdram_responder #(
  parameter int WordLength    = 16,
  parameter int BankAddrLen   = 2,
  parameter int RowAddrLen    = 13,
  parameter int ColAddrLen    = 9,
  parameter int StoreAddrBits = 10,
  parameter int TrcdCycles    = 2,
  parameter int TrpCycles     = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_clk_en,
  input  logic                   i_cs_n,
  input  logic                   i_ras_n,
  input  logic                   i_cas_n,
  input  logic                   i_we_n,
  input  logic [12:0]            i_addr,
  input  logic [BankAddrLen-1:0] i_bank,
  input  logic [1:0]             i_dqm,
  inout  wire  [WordLength-1:0]  io_data,
  output logic                   o_mode_set,
  output logic                   o_error,
  output logic [2:0]             o_err_code,
  output logic [15:0]            o_refresh_count
);

  localparam int NB    = 1 << BankAddrLen;
  localparam int Depth = 1 << StoreAddrBits;
  localparam int TW    = 4;
  localparam int HW    = WordLength / 2;
  localparam logic [TW-1:0] TMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RDW,
    S_RD
  } state_e;

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [ColAddrLen-1:0] bcol_q, bcol_d;
  logic [BankAddrLen-1:0] bbank_q, bbank_d;
  logic [RowAddrLen-1:0] brow_q, brow_d;
  logic bap_q, bap_d;
  logic [1:0] bcode_q, bcode_d;
  logic oe_q, oe_d;

  logic mode_set_q, mode_set_d;
  logic [1:0] blc_q, blc_d;
  logic cl3_q, cl3_d;
  logic wsgl_q, wsgl_d;

  logic [NB-1:0] open_q, open_d;
  logic [RowAddrLen-1:0] row_q [NB];
  logic [RowAddrLen-1:0] row_d [NB];
  logic [TW-1:0] trcd_q [NB];
  logic [TW-1:0] trcd_d [NB];
  logic [TW-1:0] trp_q [NB];
  logic [TW-1:0] trp_d [NB];

  logic err_q, err_d;
  logic [2:0] code_q, code_d;
  logic [15:0] ref_q, ref_d;

  logic [WordLength-1:0] mem_q [Depth];
  logic [WordLength-1:0] dout_q;

  logic we, ren;
  logic [StoreAddrBits-1:0] waddr, raddr;
  logic [1:0] wcode;
  logic [2:0] ecode;

  function automatic logic [2:0] last_idx(input logic [1:0] code);
    logic [2:0] r;
    unique case (code)
      2'd0: r = 3'd0;
      2'd1: r = 3'd1;
      2'd2: r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  // Sequential order that wraps inside the BL-aligned column block
  function automatic logic [ColAddrLen-1:0] wcol(
    input logic [ColAddrLen-1:0] s,
    input logic [2:0]            i,
    input logic [1:0]            code
  );
    logic [ColAddrLen-1:0] m;
    m = ColAddrLen'(last_idx(code));
    return (s & ~m) | ((s + ColAddrLen'(i)) & m);
  endfunction

  function automatic logic [StoreAddrBits-1:0] sidx(
    input logic [BankAddrLen-1:0] b,
    input logic [RowAddrLen-1:0]  r,
    input logic [ColAddrLen-1:0]  c
  );
    return StoreAddrBits'({b, r, c});
  endfunction

  logic cmd_v;
  logic [2:0] cmd;
  logic is_act, is_rd, is_wr, is_pre;
  logic is_ref, is_lmr, is_bst;
  logic busy, mode_ok, trunc;

  assign cmd_v  = i_clk_en & ~i_cs_n;
  assign cmd    = {i_ras_n, i_cas_n, i_we_n};
  assign is_act = cmd_v & (cmd == 3'b011);
  assign is_rd  = cmd_v & (cmd == 3'b101);
  assign is_wr  = cmd_v & (cmd == 3'b100);
  assign is_pre = cmd_v & (cmd == 3'b010);
  assign is_ref = cmd_v & (cmd == 3'b001);
  assign is_lmr = cmd_v & (cmd == 3'b000);
  assign is_bst = cmd_v & (cmd == 3'b110);
  assign busy   = (state_q != S_IDLE);
  assign mode_ok = ~i_addr[2] &
                   ((i_addr[6:4] == 3'd2) | (i_addr[6:4] == 3'd3));
  assign trunc  = ((is_rd | is_wr) & (ecode == 3'd0)) | is_pre;

  always_comb begin
    ecode = 3'd0;
    unique case (1'b1)
      is_act: begin
        if (!mode_set_q) ecode = 3'd1;
        else if (busy) ecode = 3'd6;
        else if (open_q[i_bank] ||
                 trp_q[i_bank] < TW'(TrpCycles)) ecode = 3'd3;
      end
      is_rd, is_wr: begin
        if (!mode_set_q) ecode = 3'd1;
        else if (!open_q[i_bank] ||
                 trcd_q[i_bank] < TW'(TrcdCycles)) ecode = 3'd4;
      end
      is_ref: begin
        if (busy) ecode = 3'd6;
        else if (|open_q) ecode = 3'd5;
      end
      is_lmr: begin
        if (busy) ecode = 3'd6;
        else if (!mode_ok) ecode = 3'd2;
      end
      is_bst: ecode = 3'd7;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcol_d     = bcol_q;
    bbank_d    = bbank_q;
    brow_d     = brow_q;
    bap_d      = bap_q;
    bcode_d    = bcode_q;
    oe_d       = oe_q;
    mode_set_d = mode_set_q;
    blc_d      = blc_q;
    cl3_d      = cl3_q;
    wsgl_d     = wsgl_q;
    open_d     = open_q;
    row_d      = row_q;
    trcd_d     = trcd_q;
    trp_d      = trp_q;
    err_d      = err_q;
    code_d     = code_q;
    ref_d      = ref_q;
    wcode      = wsgl_q ? 2'd0 : blc_q;
    we         = 1'b0;
    waddr      = '0;
    ren        = 1'b0;
    raddr      = '0;
    if (i_clk_en) begin
      for (int b = 0; b < NB; b++) begin
        if (trcd_q[b] != TMAX) trcd_d[b] = trcd_q[b] + 1'b1;
        if (trp_q[b] != TMAX) trp_d[b] = trp_q[b] + 1'b1;
      end
      if (!trunc) begin
        unique case (state_q)
          S_WR: begin
            we    = 1'b1;
            waddr = sidx(bbank_q, brow_q,
                         wcol(bcol_q, cnt_q, bcode_q));
            if (cnt_q == last_idx(bcode_q)) begin
              state_d = S_IDLE;
              if (bap_q) begin
                open_d[bbank_q] = 1'b0;
                trp_d[bbank_q]  = TW'(1);
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          S_RDW: begin
            if (cnt_q == 3'd0) begin
              state_d = S_RD;
              oe_d    = 1'b1;
              ren     = 1'b1;
              raddr   = sidx(bbank_q, brow_q,
                             wcol(bcol_q, 3'd0, bcode_q));
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
          S_RD: begin
            if (cnt_q == last_idx(bcode_q)) begin
              state_d = S_IDLE;
              oe_d    = 1'b0;
              if (bap_q) begin
                open_d[bbank_q] = 1'b0;
                trp_d[bbank_q]  = TW'(1);
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              ren   = 1'b1;
              raddr = sidx(bbank_q, brow_q,
                           wcol(bcol_q, cnt_q + 3'd1, bcode_q));
            end
          end
          default: ;
        endcase
      end
      if (ecode != 3'd0) begin
        if (!err_q) begin
          err_d  = 1'b1;
          code_d = ecode;
        end
        if (ecode == 3'd2) mode_set_d = 1'b0;
      end else begin
        unique case (1'b1)
          is_act: begin
            open_d[i_bank] = 1'b1;
            row_d[i_bank]  = i_addr[RowAddrLen-1:0];
            trcd_d[i_bank] = TW'(1);
          end
          is_rd: begin
            state_d = S_RDW;
            cnt_d   = {2'b00, cl3_q};
            bcol_d  = i_addr[ColAddrLen-1:0];
            bbank_d = i_bank;
            brow_d  = row_q[i_bank];
            bap_d   = i_addr[10];
            bcode_d = blc_q;
            oe_d    = 1'b0;
          end
          is_wr: begin
            we      = 1'b1;
            waddr   = sidx(i_bank, row_q[i_bank],
                           i_addr[ColAddrLen-1:0]);
            bcol_d  = i_addr[ColAddrLen-1:0];
            bbank_d = i_bank;
            brow_d  = row_q[i_bank];
            bap_d   = i_addr[10];
            bcode_d = wcode;
            oe_d    = 1'b0;
            cnt_d   = 3'd1;
            state_d = (wcode == 2'd0) ? S_IDLE : S_WR;
            if (wcode == 2'd0 && i_addr[10]) begin
              open_d[i_bank] = 1'b0;
              trp_d[i_bank]  = TW'(1);
            end
          end
          is_pre: begin
            for (int b = 0; b < NB; b++) begin
              if (i_addr[10] || BankAddrLen'(b) == i_bank) begin
                open_d[b] = 1'b0;
                trp_d[b]  = TW'(1);
              end
            end
            state_d = S_IDLE;
            oe_d    = 1'b0;
          end
          is_ref: ref_d = ref_q + 16'd1;
          is_lmr: begin
            mode_set_d = 1'b1;
            blc_d      = i_addr[1:0];
            cl3_d      = i_addr[4];
            wsgl_d     = i_addr[9];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bcol_q     <= '0;
      bbank_q    <= '0;
      brow_q     <= '0;
      bap_q      <= 1'b0;
      bcode_q    <= '0;
      oe_q       <= 1'b0;
      mode_set_q <= 1'b0;
      blc_q      <= '0;
      cl3_q      <= 1'b0;
      wsgl_q     <= 1'b0;
      open_q     <= '0;
      err_q      <= 1'b0;
      code_q     <= '0;
      ref_q      <= '0;
      for (int b = 0; b < NB; b++) begin
        row_q[b]  <= '0;
        trcd_q[b] <= TMAX;
        trp_q[b]  <= TMAX;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcol_q     <= bcol_d;
      bbank_q    <= bbank_d;
      brow_q     <= brow_d;
      bap_q      <= bap_d;
      bcode_q    <= bcode_d;
      oe_q       <= oe_d;
      mode_set_q <= mode_set_d;
      blc_q      <= blc_d;
      cl3_q      <= cl3_d;
      wsgl_q     <= wsgl_d;
      open_q     <= open_d;
      err_q      <= err_d;
      code_q     <= code_d;
      ref_q      <= ref_d;
      row_q      <= row_d;
      trcd_q     <= trcd_d;
      trp_q      <= trp_d;
    end
  end

  // Backing store keeps its contents across reset
  always_ff @(posedge CLK) begin
    if (we && !RST) begin
      if (!i_dqm[0]) mem_q[waddr][HW-1:0] <= io_data[HW-1:0];
      if (!i_dqm[1]) mem_q[waddr][WordLength-1:HW] <= io_data[WordLength-1:HW];
    end
    if (ren) dout_q <= mem_q[raddr];
  end

  assign io_data         = oe_q ? dout_q : {WordLength{1'bz}};
  assign o_mode_set      = mode_set_q;
  assign o_error         = err_q;
  assign o_err_code      = code_q;
  assign o_refresh_count = ref_q;

endmodule
